// File: rtl/cia_todgen_pkg.sv
// cia_todgen_pkg: shared constants and types for the CIA TOD generator.
//   TOD_HZ_50 / TOD_HZ_60  nominal TOD frequencies
//   todsrc_t               which source drives the CIA TOD input
//   half_n / half_r        quotient and remainder of clk_hz/(2f), used to
//                          build the fractional half-period divider
package cia_todgen_pkg;

  localparam int TOD_HZ_50 = 50;
  localparam int TOD_HZ_60 = 60;

  typedef enum logic {
    TODSRC_GEN = 1'b0,
    TODSRC_EXT = 1'b1
  } todsrc_t;

  function automatic int half_n(input int clk_hz, input int f);
    return clk_hz / (2 * f);
  endfunction

  function automatic int half_r(input int clk_hz, input int f);
    return clk_hz % (2 * f);
  endfunction

endpackage

// File: rtl/cia_todgen_div.sv
// cia_todgen_div: fractional divider producing a 50/60 Hz square wave with an
// exact average frequency. Each half period is N clk cycles; the remainder R
// is accumulated at every toggle and, when it reaches 2f, the next half
// period is stretched by one cycle.
// Ports:
//   clk, res   clock, asynchronous active-high reset
//   en         0 holds gen low and clears the divider state
//   sel60      0 = 50 Hz, 1 = 60 Hz; sampled only when gen rises
//   gen        generated square wave (starts with a low half period)
//   gen_rise   one-cycle pulse in the first cycle gen is high
module cia_todgen_div
  import cia_todgen_pkg::*;
#(
  parameter int CLK_HZ = 24000000
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic sel60,
  output logic gen,
  output logic gen_rise
);

  localparam int N50 = half_n(CLK_HZ, TOD_HZ_50);
  localparam int N60 = half_n(CLK_HZ, TOD_HZ_60);
  localparam int R50 = half_r(CLK_HZ, TOD_HZ_50);
  localparam int R60 = half_r(CLK_HZ, TOD_HZ_60);
  localparam int CW  = $clog2(N50 + 2);
  // err < 2f and R < 2f, so err + R < 4*60
  localparam int EW  = $clog2(4 * TOD_HZ_60);

  localparam logic [CW-1:0] LEN50 = CW'(N50);
  localparam logic [CW-1:0] LEN60 = CW'(N60);
  localparam logic [EW-1:0] REM50 = EW'(R50);
  localparam logic [EW-1:0] REM60 = EW'(R60);
  localparam logic [EW-1:0] PER50 = EW'(2 * TOD_HZ_50);
  localparam logic [EW-1:0] PER60 = EW'(2 * TOD_HZ_60);

  logic [CW-1:0] cnt;
  logic [EW-1:0] err;
  logic          extra;  // current half period is N+1
  logic          f60;    // frequency of the period in progress

  logic [CW-1:0] len;
  logic          fn;
  logic [EW-1:0] rn, pn, acc;
  logic          last;

  always_comb begin
    len  = (f60 ? LEN60 : LEN50) + CW'(extra);
    // a rising toggle starts a new period, which picks up sel60
    fn   = gen ? f60 : sel60;
    rn   = fn ? REM60 : REM50;
    pn   = fn ? PER60 : PER50;
    acc  = err + rn;
    last = (cnt == len - CW'(1));
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt      <= '0;
      err      <= '0;
      extra    <= 1'b0;
      f60      <= 1'b0;
      gen      <= 1'b0;
      gen_rise <= 1'b0;
    end else begin
      gen_rise <= 1'b0;
      if (!en) begin
        cnt   <= '0;
        err   <= '0;
        extra <= 1'b0;
        gen   <= 1'b0;
      end else if (last) begin
        cnt      <= '0;
        gen      <= ~gen;
        gen_rise <= ~gen;
        f60      <= fn;
        if (!gen && (sel60 != f60)) begin
          // frequency change: restart the fractional phase
          err   <= '0;
          extra <= 1'b0;
        end else if (acc >= pn) begin
          err   <= acc - pn;
          extra <= 1'b1;
        end else begin
          err   <= acc;
          extra <= 1'b0;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cia_todgen.sv
// cia_todgen: TOD square-wave source for the CIA TOD input.
// Optional build macro CIA_TODGEN_AUTO_EN: when defined, an external TOD pin
// is synchronized and watched; once it shows VALID_EDGES consecutive sane
// intervals it replaces the generator, and it is dropped again on a glitch
// or a timeout. Without the macro tod_ext is ignored and ext_present is 0.
// Ports:
//   clk, res     clock, asynchronous active-high reset
//   en           generator enable
//   sel60        0 = 50 Hz, 1 = 60 Hz
//   tod_ext      raw external TOD pin (asynchronous)
//   tod_out      TOD signal to the CIA (registered)
//   tod_tick     one-cycle pulse on each tod_out rising edge (registered)
//   ext_present  external source is the one currently driving tod_out
module cia_todgen
  import cia_todgen_pkg::*;
#(
  parameter int CLK_HZ      = 24000000,
  parameter int TIMEOUT_CYC = CLK_HZ / 10,
  parameter int MINPER_CYC  = CLK_HZ / 70,
  parameter int VALID_EDGES = 3
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic sel60,
  input  logic tod_ext,
  output logic tod_out,
  output logic tod_tick,
  output logic ext_present
);

  logic    gen, gen_rise;
  logic    ext_s1;
  todsrc_t src;

  cia_todgen_div #(.CLK_HZ(CLK_HZ)) u_div (
    .clk      (clk),
    .res      (res),
    .en       (en),
    .sel60    (sel60),
    .gen      (gen),
    .gen_rise (gen_rise)
  );

`ifdef CIA_TODGEN_AUTO_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int VW = $clog2(VALID_EDGES + 1);

  logic          ext_s2, ext_s3;
  logic [IW-1:0] icnt;   // cycles since last ext_sync rising edge, saturating
  logic [VW-1:0] vcnt;
  logic          ext_rise, tmo, glitch, valid_iv, both_low;
  todsrc_t       req;

  always_comb begin
    ext_rise = ext_s2 & ~ext_s3;
    tmo      = (icnt == IW'(TIMEOUT_CYC));
    glitch   = ext_rise && (icnt < IW'(MINPER_CYC));
    valid_iv = ext_rise && !glitch && !tmo;
    req      = (vcnt == VW'(VALID_EDGES)) ? TODSRC_EXT : TODSRC_GEN;
    // ext_s1 feeds tod_out directly, so it must be low as well as ext_sync
    both_low = ~ext_s1 & ~ext_s2 & ~gen;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ext_s1 <= 1'b0;
      ext_s2 <= 1'b0;
      ext_s3 <= 1'b0;
      icnt   <= '0;
      vcnt   <= '0;
      src    <= TODSRC_GEN;
    end else begin
      ext_s1 <= tod_ext;
      ext_s2 <= ext_s1;
      ext_s3 <= ext_s2;
      if (ext_rise)  icnt <= IW'(1);
      else if (!tmo) icnt <= icnt + IW'(1);
      // an edge in the timeout cycle wins over the timeout
      if (glitch || (tmo && !ext_rise))
        vcnt <= '0;
      else if (valid_iv && (vcnt != VW'(VALID_EDGES)))
        vcnt <= vcnt + VW'(1);
      if (both_low) src <= req;
    end
  end

  assign ext_present = (src == TODSRC_EXT);
`else
  logic unused_cfg;
  assign unused_cfg  = tod_ext ^ (TIMEOUT_CYC > 0) ^ (MINPER_CYC > 0) ^ (VALID_EDGES > 0);
  assign ext_s1      = 1'b0;
  assign src         = TODSRC_GEN;
  assign ext_present = 1'b0;
`endif

  // tod_out acts as the second synchronizer stage on the external path,
  // giving two clk of latency from tod_ext.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      tod_out  <= 1'b0;
      tod_tick <= 1'b0;
    end else if (src == TODSRC_EXT) begin
      tod_out  <= ext_s1;
      tod_tick <= ext_s1 & ~tod_out;
    end else begin
      // switchover only happens with gen low, so gen_rise == gen & ~tod_out
      tod_out  <= gen;
      tod_tick <= gen_rise;
    end
  end

endmodule
